// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, the NOP encoding,
// the default reset vector, base opcodes and a word-alignment helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Force an address onto a 4-byte boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Fetch output register: holds one instruction, its address and address+4
// for decode, with a valid/ready handshake and a flush on redirect.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_4,
  output logic [6:0]  op,
  output logic [2:0]  funct_3,
  output logic        funct_7_5,
  output logic        fire
);

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic [31:0] pc_plus_4_r;
  logic        fire_s;

  assign fire_s = valid_r & ready;

  // Capture a returned word, keep it stable until consumed, drop it on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      instr_r     <= NOP_INSTR;
      instr_pc_r  <= RESET_PC;
      pc_plus_4_r <= RESET_PC + 32'd4;
    end else if (load) begin
      valid_r     <= 1'b1;
      instr_r     <= load_instr;
      instr_pc_r  <= load_pc;
      pc_plus_4_r <= load_pc + 32'd4;
    end else if (flush || fire_s) begin
      valid_r     <= 1'b0;
    end
  end

  assign valid     = valid_r;
  assign instr     = instr_r;
  assign instr_pc  = instr_pc_r;
  assign pc_plus_4 = pc_plus_4_r;
  assign op        = instr_r[6:0];
  assign funct_3   = instr_r[14:12];
  assign funct_7_5 = instr_r[30];
  assign fire      = fire_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register and IDLE/REQ/WAIT/HOLD fetch FSM with a
// single outstanding memory request and redirect handling.
// Optional build macro FETCH_STATS_EN adds the FETCH_COUNT accepted-instruction counter.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        PC_SRC,
  input  logic [31:0] PC_TARGET,
`ifdef FETCH_STATS_EN
  output logic [31:0] FETCH_COUNT,
`endif
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic [31:0] PC_PLUS_4,
  output logic [6:0]  OP,
  output logic [2:0]  FUNCT_3,
  output logic        FUNCT_7_5
);

  fetch_state_t state_r, next_state_s;
  logic [31:0]  pc_r, next_pc_s;
  logic [31:0]  req_pc_r;
  logic         drop_r, next_drop_s;
  logic         imem_req_r;
  logic         load_s;
  logic         fire_s;

  // State, PC, drop flag, in-flight address and registered request strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      drop_r     <= 1'b0;
      req_pc_r   <= RESET_PC;
      imem_req_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= next_pc_s;
      drop_r     <= next_drop_s;
      imem_req_r <= (next_state_s == REQ);
      if (state_r == REQ && IMEM_GNT) begin
        req_pc_r <= pc_r;
      end
    end
  end

  // Next-state logic; a redirect while a request is in flight marks its response stale.
  always_comb begin
    next_state_s = state_r;
    next_drop_s  = drop_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = REQ;
      end
      REQ: begin
        if (IMEM_GNT) begin
          next_state_s = WAIT;
          next_drop_s  = PC_SRC;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (IMEM_RVALID) begin
          if (drop_r || PC_SRC) begin
            next_drop_s  = 1'b0;
            next_state_s = REQ;
          end else begin
            load_s       = 1'b1;
            next_state_s = HOLD;
          end
        end else if (PC_SRC) begin
          next_drop_s  = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      HOLD: begin
        if (PC_SRC || fire_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_drop_s  = 1'b0;
      end
    endcase
  end

  // Next PC: redirect wins over the sequential increment taken on grant.
  always_comb begin
    next_pc_s = pc_r;
    if (PC_SRC) begin
      next_pc_s = align_word(PC_TARGET);
    end else if (state_r == REQ && IMEM_GNT) begin
      next_pc_s = pc_r + 32'd4;
    end else begin
      next_pc_s = pc_r;
    end
  end

  assign IMEM_REQ  = imem_req_r;
  assign IMEM_ADDR = pc_r;

  fetch_buffer #(.RESET_PC(RESET_PC)) u_buffer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .load       (load_s),
    .load_instr (IMEM_RDATA),
    .load_pc    (req_pc_r),
    .flush      (PC_SRC),
    .ready      (INSTR_READY),
    .valid      (INSTR_VALID),
    .instr      (INSTR),
    .instr_pc   (INSTR_PC),
    .pc_plus_4  (PC_PLUS_4),
    .op         (OP),
    .funct_3    (FUNCT_3),
    .funct_7_5  (FUNCT_7_5),
    .fire       (fire_s)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_r;

  // Count instructions accepted by decode; wraps modulo 2^32.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_count_r <= 32'd0;
    end else if (fire_s) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end
  end

  assign FETCH_COUNT = fetch_count_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction table, memory responder,
// scoreboard of expected fetches, and hand sequences for redirect/reset/wrap.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'd0;
  logic        PC_SRC = 1'b0;
  logic [31:0] PC_TARGET = 32'd0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR, INSTR_PC, PC_PLUS_4;
  logic [6:0]  OP;
  logic [2:0]  FUNCT_3;
  logic        FUNCT_7_5;
`ifdef FETCH_STATS_EN
  logic [31:0] FETCH_COUNT;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .PC_SRC(PC_SRC), .PC_TARGET(PC_TARGET),
`ifdef FETCH_STATS_EN
    .FETCH_COUNT(FETCH_COUNT),
`endif
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC), .PC_PLUS_4(PC_PLUS_4),
    .OP(OP), .FUNCT_3(FUNCT_3), .FUNCT_7_5(FUNCT_7_5)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
  } exp_t;

  localparam int NV = 7;
  vec_t tbl [NV];
  exp_t q [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic have_last = 1'b0;
  logic rate_chk = 1'b0;
  logic gnt_en = 1'b0;
  int lat = 1;
  int pend_cnt = 0;
  logic [31:0] pend_addr = 32'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[29:0], 2'b11} ^ 32'hA5A5_0000;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].addr == a) w = tbl[i].data;
    end
    return w;
  endfunction

  task automatic push_addr(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    e.op    = e.instr[6:0];
    e.f3    = e.instr[14:12];
    e.f75   = e.instr[30];
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].addr == a) begin
        e.op  = tbl[i].op;
        e.f3  = tbl[i].f3;
        e.f75 = tbl[i].f75;
      end
    end
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_granted(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (IMEM_REQ && n < budget);
    chk(name, 32'(IMEM_REQ), 32'd0);
  endtask

  // Memory responder: grants a request immediately when enabled, returns data lat cycles later.
  initial begin
    forever begin
      @(negedge CLK);
      IMEM_GNT    = 1'b0;
      IMEM_RVALID = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          IMEM_RVALID = 1'b1;
          IMEM_RDATA  = mem_word(pend_addr);
        end
      end
      if (IMEM_REQ && gnt_en && pend_cnt == 0) begin
        IMEM_GNT  = 1'b1;
        pend_addr = IMEM_ADDR;
        pend_cnt  = lat;
      end
    end
  end

  // Scoreboard: every decode-side accept is checked against the oldest expected fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!rate_chk) have_last = 1'b0;
      if (INSTR_VALID && INSTR_READY) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_fire: got pc %h, expected no instruction", INSTR_PC);
        end else begin
          e = q.pop_front();
          chk("instr_pc", INSTR_PC, e.pc);
          chk("instr", INSTR, e.instr);
          chk("pc_plus_4", PC_PLUS_4, e.pc + 32'd4);
          chk("op", 32'(OP), 32'(e.op));
          chk("funct_3", 32'(FUNCT_3), 32'(e.f3));
          chk("funct_7_5", 32'(FUNCT_7_5), 32'(e.f75));
        end
        if (rate_chk && have_last) chk("rate", 32'(cyc - last_cyc), 32'd3);
        last_cyc  = cyc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0000, 32'h00A3_0063, 7'h63, 3'd0, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h40B5_0533, 7'h33, 3'd0, 1'b1};
    tbl[2] = '{32'h0000_0008, 32'h0045_2583, 7'h03, 3'd2, 1'b0};
    tbl[3] = '{32'h0000_000C, 32'h0000_0013, 7'h13, 3'd0, 1'b0};
    tbl[4] = '{32'h0000_0010, 32'h4010_D093, 7'h13, 3'd5, 1'b1};
    tbl[5] = '{32'h0000_0014, 32'h1234_50B7, 7'h37, 3'd5, 1'b0};
    tbl[6] = '{32'h0000_0018, 32'h00A3_0063, 7'h63, 3'd0, 1'b0};

    // Reset values
    repeat (3) tick();
    chk("rst_imem_req", 32'(IMEM_REQ), 32'd0);
    chk("rst_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_instr", INSTR, 32'h0000_0013);
    chk("rst_instr_pc", INSTR_PC, 32'h0000_0000);
`ifdef FETCH_STATS_EN
    chk("rst_count", FETCH_COUNT, 32'd0);
`endif

    // Back-to-back fetches from the table at full rate
    for (int i = 0; i < 6; i++) push_addr(tbl[i].addr);
    INSTR_READY = 1'b1;
    gnt_en      = 1'b1;
    rate_chk    = 1'b1;
    RESET_N     = 1'b1;
    #1;
    chk("idle_no_req", 32'(IMEM_REQ), 32'd0);
    @(posedge CLK);
    #1;
    chk("first_req", 32'(IMEM_REQ), 32'd1);
    chk("first_addr", IMEM_ADDR, 32'h0000_0000);
    wait_empty("stream_drain", 60);
    gnt_en   = 1'b0;
    rate_chk = 1'b0;

    // Held instruction with decode stalled
    INSTR_READY = 1'b0;
    push_addr(tbl[6].addr);
    gnt_en = 1'b1;
    for (int n = 0; n < 20 && !INSTR_VALID; n++) tick();
    chk("hold_valid", 32'(INSTR_VALID), 32'd1);
    gnt_en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("hold_instr", INSTR, 32'h00A3_0063);
      chk("hold_op", 32'(OP), 32'h63);
      chk("hold_f3", 32'(FUNCT_3), 32'd0);
      chk("hold_no_req", 32'(IMEM_REQ), 32'd0);
    end
    INSTR_READY = 1'b1;
    wait_empty("hold_drain", 10);

    // Redirect while waiting for a slow response
    lat    = 2;
    gnt_en = 1'b1;
    wait_granted("wait_entry", 10);
    PC_SRC    = 1'b1;
    PC_TARGET = 32'h0000_0102;
    gnt_en    = 1'b0;
    tick();
    PC_SRC = 1'b0;
    chk("drop_wait_no_req", 32'(IMEM_REQ), 32'd0);
    tick();
    chk("redir_req", 32'(IMEM_REQ), 32'd1);
    chk("redir_addr", IMEM_ADDR, 32'h0000_0100);
    chk("redir_no_valid", 32'(INSTR_VALID), 32'd0);
    lat = 1;
    push_addr(32'h0000_0100);
    gnt_en = 1'b1;
    wait_empty("redir_drain", 10);
    gnt_en = 1'b0;

    // Redirect coinciding with grant
    push_addr(32'h0000_0200);
    PC_SRC    = 1'b1;
    PC_TARGET = 32'h0000_0200;
    gnt_en    = 1'b1;
    tick();
    PC_SRC = 1'b0;
    chk("gnt_redir_wait", 32'(IMEM_REQ), 32'd0);
    tick();
    chk("gnt_redir_req", 32'(IMEM_REQ), 32'd1);
    chk("gnt_redir_addr", IMEM_ADDR, 32'h0000_0200);
    wait_empty("gnt_redir_drain", 10);
    gnt_en = 1'b0;

    // Address wrap at the top of memory, unaligned target
    push_addr(32'hFFFF_FFFC);
    push_addr(32'h0000_0000);
    PC_SRC    = 1'b1;
    PC_TARGET = 32'hFFFF_FFFE;
    tick();
    PC_SRC = 1'b0;
    chk("top_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    gnt_en = 1'b1;
    wait_empty("wrap_drain", 20);
    gnt_en = 1'b0;

    // Reset while a request is outstanding; late response must be ignored
    lat    = 2;
    gnt_en = 1'b1;
    wait_granted("rst_wait_entry", 10);
    RESET_N = 1'b0;
    gnt_en  = 1'b0;
    #1;
    chk("midrst_valid", 32'(INSTR_VALID), 32'd0);
    chk("midrst_instr", INSTR, 32'h0000_0013);
    chk("midrst_req", 32'(IMEM_REQ), 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("late_valid", 32'(INSTR_VALID), 32'd0);
    chk("late_instr", INSTR, 32'h0000_0013);
    chk("late_req", 32'(IMEM_REQ), 32'd1);
    chk("late_addr", IMEM_ADDR, 32'h0000_0000);
    tick();
    chk("late_valid2", 32'(INSTR_VALID), 32'd0);
    lat = 1;

    // Three accepts after reset
    for (int i = 0; i < 3; i++) push_addr(tbl[i].addr);
    rate_chk = 1'b1;
    gnt_en   = 1'b1;
    wait_empty("post_rst_drain", 30);
    gnt_en   = 1'b0;
    rate_chk = 1'b0;
`ifdef FETCH_STATS_EN
    chk("fetch_count", FETCH_COUNT, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
